// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: stage register enables and bubbles,
// PC update and source select, trap/mret sequencing, and a stalled-fetch counter.
module pipe_hazard_ctrl #(
   parameter int          CNT_W        = 16,
   parameter logic [1:0]  TRAP_VEC_SEL = 2'd2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             uses_rs1_id,
   input  logic             uses_rs2_id,
   input  logic [4:0]       rd_ex,
   input  logic             mem_read_ex,
   input  logic             branch_taken_ex,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   input  logic             trap_wb,
   input  logic             mret_wb,
   output logic             pc_en,
   output logic [1:0]       pc_sel,
   output logic             en_if_id,
   output logic             en_id_ex,
   output logic             en_ex_mem,
   output logic             en_mem_wb,
   output logic             clear_if_id,
   output logic             clear_id_ex,
   output logic             clear_ex_mem,
   output logic             clear_mem_wb,
   output logic             trap_taken,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] SEL_SEQ    = 2'd0;
   localparam logic [1:0] SEL_BRANCH = 2'd1;
   localparam logic [1:0] SEL_MEPC   = 2'd3;

   typedef enum logic {RUN, DRAIN} state_e;

   state_e     state_q;
   logic       kind_trap_q;
   logic       redirect, load_use;
   logic [3:0] en_v, clr_v;   // [0]=IF/ID .. [3]=MEM/WB

   assign redirect = trap_wb | mret_wb;
   assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                     ((uses_rs1_id && (rs1_id == rd_ex)) ||
                      (uses_rs2_id && (rs2_id == rd_ex)));

   always_comb begin
      en_v       = 4'b1111;
      clr_v      = 4'b0000;
      pc_en      = 1'b1;
      pc_sel     = SEL_SEQ;
      trap_taken = 1'b0;
      if (rst_i) begin
         clr_v = 4'b1111;
         pc_en = 1'b0;
      end else if (state_q == DRAIN) begin
         // MEM/WB is frozen, so the redirect commits once the data access returns
         if (dmem_busy) begin
            en_v  = 4'b0000;
            pc_en = 1'b0;
         end else begin
            clr_v      = 4'b1111;
            pc_sel     = kind_trap_q ? TRAP_VEC_SEL : SEL_MEPC;
            trap_taken = 1'b1;
         end
      end else if (redirect && !dmem_busy) begin
         clr_v      = 4'b1111;
         pc_sel     = trap_wb ? TRAP_VEC_SEL : SEL_MEPC;
         trap_taken = 1'b1;
      end else if (redirect) begin
         en_v  = 4'b0000;
         pc_en = 1'b0;
      end else if (dmem_busy) begin
         en_v  = 4'b1000;
         clr_v = 4'b1000;
         pc_en = 1'b0;
      end else if (branch_taken_ex) begin
         clr_v  = 4'b0011;
         pc_sel = SEL_BRANCH;
      end else if (load_use) begin
         en_v  = 4'b1110;
         clr_v = 4'b0010;
         pc_en = 1'b0;
      end else if (imem_busy) begin
         clr_v = 4'b0001;
         pc_en = 1'b0;
      end
   end

   assign {en_mem_wb, en_ex_mem, en_id_ex, en_if_id}             = en_v | clr_v;
   assign {clear_mem_wb, clear_ex_mem, clear_id_ex, clear_if_id} = clr_v;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         kind_trap_q <= 1'b1;
         stall_cnt   <= '0;
      end else begin
         case (state_q)
            RUN: if (redirect && dmem_busy) begin
               state_q     <= DRAIN;
               kind_trap_q <= trap_wb;
            end
            DRAIN: if (!dmem_busy) state_q <= RUN;
            default: state_q <= RUN;
         endcase
         if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage core. Drives the en/clear pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC update and PC source select. Resolves load-use hazards, taken branches, instruction and data memory wait states, and trap/mret redirection. A small FSM sequences a trap that arrives while a data access is still outstanding. A saturating counter reports the number of stalled fetch cycles.

Parameters:
CNT_W, 16, width of the stall-cycle counter
TRAP_VEC_SEL, 2'd2, pc_sel encoding for the trap vector (mret uses 2'd3, branch 2'd1, sequential 2'd0; fixed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
rs1_id  in  5  ID-stage source register 1
rs2_id  in  5  ID-stage source register 2
uses_rs1_id  in  1  ID instruction reads rs1
uses_rs2_id  in  1  ID instruction reads rs2
rd_ex  in  5  EX-stage destination register
mem_read_ex  in  1  EX-stage instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch/jump
imem_busy  in  1  instruction fetch not yet returned
dmem_busy  in  1  MEM-stage data access outstanding
trap_wb  in  1  trapping instruction in WB
mret_wb  in  1  mret in WB
pc_en  out  1  PC register load enable
pc_sel  out  2  0 PC+4, 1 branch target, 2 trap vector, 3 mepc
en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  stage register enables
clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb  out  1 each  bubble insert
trap_taken  out  1  one-cycle pulse when the trap/mret redirect commits
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- Outputs are combinational from the registered state and the current inputs. State, the latched kind and stall_cnt are registered.
- Whenever clear_x=1, en_x is also driven to 1.
- FSM states: RUN, DRAIN.
- Reset (rst_i=1):
  - state becomes RUN, the latched kind becomes trap, stall_cnt becomes 0.
  - During reset all clear_*=1, pc_en=0, pc_sel=0, trap_taken=0.
  - Reset in DRAIN abandons the pending redirect.
- RUN, priority high to low:
  1. Redirect (trap_wb|mret_wb), dmem_busy=0:
     - all four clear_*=1, pc_en=1, trap_taken=1; stay in RUN.
     - pc_sel=2 if trap_wb, else 3; trap wins if both are set.
  2. Redirect, dmem_busy=1:
     - latch the kind (trap if trap_wb); next state DRAIN.
     - this cycle: all en_*=0, clears=0, pc_en=0.
  3. dmem_busy=1 (no redirect):
     - pc_en=0; en_if_id=en_id_ex=en_ex_mem=0.
     - clear_mem_wb=1 (bubble into WB).
  4. branch_taken_ex=1:
     - pc_en=1, pc_sel=1; clear_if_id=1, clear_id_ex=1; EX/MEM and MEM/WB enabled.
     - Overrides imem_busy and load-use; the fetch unit drops the in-flight fetch.
  5. Load-use: mem_read_ex & rd_ex!=0 & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)):
     - pc_en=0, en_if_id=0, clear_id_ex=1; later stages enabled.
     - Lasts exactly 1 cycle, since the load then leaves EX.
  6. imem_busy=1:
     - pc_en=0, clear_if_id=1; ID/EX, EX/MEM and MEM/WB enabled.
  7. Otherwise: all en_*=1, clears=0, pc_en=1, pc_sel=0.
- DRAIN:
  - All en_*=0, clears=0, pc_en=0; trap_wb/mret_wb are held by the frozen MEM/WB register.
  - When dmem_busy=0: all clear_*=1, pc_en=1, pc_sel from the latched kind, trap_taken=1; next state RUN.
  - branch_taken_ex, imem_busy and load-use are ignored in DRAIN.
- stall_cnt: increments by 1 in every non-reset cycle with pc_en=0. It holds at 2^CNT_W-1.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs2_id=5, uses_rs2_id=1 for 1 cycle -> pc_en=0, en_if_id=0, clear_id_ex=1 that cycle; next cycle all en=1; stall_cnt=1.
- Branch plus imem_busy and load-use in the same cycle -> pc_sel=1, pc_en=1, clear_if_id=clear_id_ex=1, en_ex_mem=en_mem_wb=1; stall_cnt unchanged.
- Load-use with rd_ex=0 -> no stall; all en=1, pc_sel=0.
- trap_wb=1 with dmem_busy=1 for 3 cycles, then 0:
  - 3 cycles all en=0, pc_en=0 (DRAIN); stall_cnt +3 over those 3 cycles.
  - 4th cycle: all clear=1, pc_sel=2, trap_taken=1, stall_cnt unchanged; then back in RUN.
- trap_wb=mret_wb=1, dmem_busy=0 -> pc_sel=2, trap_taken=1 in the same cycle. Repeat with only mret_wb=1 -> pc_sel=3.
- rst_i asserted mid-DRAIN -> next cycle RUN with stall_cnt=0. Separately, with CNT_W=4, imem_busy held for 20 cycles -> stall_cnt saturates at 15.
